uart_rx_pio_ctrl: RTL and testbench

//  Controller for the UART RX path into the NIOS2 PIO-style Avalon-MM slave.

---
 rtl/uart_rx_pio_ctrl.sv | 127 ++++++++++++
 tb/tb_uart_rx_pio_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_pio_ctrl.sv
// UART RX byte FIFO behind an Avalon-MM PIO-style slave: DATA pops, STATUS/CONTROL give flow control.
// Optional interrupt output and irq_en control bit are built when UART_RX_PIO_IRQ_EN is defined.
module uart_rx_pio_ctrl #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata
`ifdef UART_RX_PIO_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   readdata_q, readdata_d;
  logic          irq_en_rd;

  logic ctrl_wr, flush, ovf_clr, empty, full, pop, push, ovf_set;
  logic unused_wdata;

  assign unused_wdata = ^writedata[31:2];

  always_comb begin
    ctrl_wr = write && (address == 2'd2);
    flush   = ctrl_wr && writedata[0];
    ovf_clr = ctrl_wr && writedata[1];
    empty   = (count_q == '0);
    full    = (count_q == DEPTH_C);
    // A flush discards any coincident pop or push, and a discarded push is not an overflow.
    pop     = read && (address == 2'd0) && !empty && !flush;
    push    = rx_valid && (!full || pop) && !flush;
    ovf_set = rx_valid && full && !pop && !flush;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = ovf_set || (overflow_q && !ovf_clr);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
    end
  end

  // Read mux is sampled every cycle; the head captured here is the byte the pop retires.
  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d = {23'b0, !empty, (empty ? 8'h00 : mem_q[rd_ptr_q])};
      2'd1:    readdata_d = {13'b0, overflow_q, full, empty, 16'(count_q)};
      2'd2:    readdata_d = {29'b0, irq_en_rd, 2'b0};
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      readdata_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;

`ifdef UART_RX_PIO_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_q, irq_d;

  always_comb begin
    irq_en_d = ctrl_wr ? writedata[2] : irq_en_q;
    irq_d    = irq_en_q && (!empty || overflow_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_en_rd = irq_en_q;
  assign irq       = irq_q;
`else
  assign irq_en_rd = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_pio_ctrl.sv
// Bench for uart_rx_pio_ctrl: directed steps plus random traffic against a queue-based FIFO model.
// Build with UART_RX_PIO_IRQ_EN defined to also exercise the interrupt path.
module tb_uart_rx_pio_ctrl;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [1:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
`ifdef UART_RX_PIO_IRQ_EN
  logic        irq;
`endif

  uart_rx_pio_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .readdata(readdata)
`ifdef UART_RX_PIO_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  int  vectors = 0;
  int  miscompares = 0;

  // Reference model: byte queue plus sticky flags.
  byte unsigned m_q[$];
  bit  m_ovf = 1'b0;
  bit  m_irq_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic [31:0] r;
    int n;
    n = m_q.size();
    case (a)
      2'd0: r = (n > 0) ? {23'b0, 1'b1, m_q[0]} : 32'h0;
      2'd1: r = {13'b0, m_ovf, (n == DEPTH), (n == 0), 16'(n)};
      2'd2: r = {29'b0, m_irq_en, 2'b0};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0;
    m_irq_en = 1'b0;
  endtask

  task automatic step(input bit rv, input byte unsigned d, input bit rd, input bit wr,
                      input logic [1:0] a, input logic [31:0] wd, input string tag);
    logic [31:0] exp_rd;
    bit exp_irq, fl, pp;
    rx_valid = rv; rx_data = d; read = rd; write = wr; address = a; writedata = wd;
    exp_rd  = model_read(a);
    exp_irq = m_irq_en && (m_q.size() > 0 || m_ovf);
    @(posedge clk);
    #1;
    chk({tag, ":readdata"}, readdata, exp_rd);
`ifdef UART_RX_PIO_IRQ_EN
    chk({tag, ":irq"}, {31'b0, irq}, {31'b0, exp_irq});
`else
    if (exp_irq) $display("note: model irq without irq build");
`endif
    fl = wr && (a == 2'd2) && wd[0];
    pp = rd && (a == 2'd0) && (m_q.size() > 0) && !fl;
    if (wr && (a == 2'd2) && wd[1]) m_ovf = 1'b0;
`ifdef UART_RX_PIO_IRQ_EN
    if (wr && (a == 2'd2)) m_irq_en = wd[2];
`endif
    if (fl) m_q.delete();
    else begin
      if (pp) void'(m_q.pop_front());
      if (rv) begin
        if (m_q.size() < DEPTH) m_q.push_back(d);
        else m_ovf = 1'b1;
      end
    end
    rx_valid = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  task automatic push(input byte unsigned d);
    step(1'b1, d, 1'b0, 1'b0, 2'd3, 32'h0, "push");
  endtask

  task automatic rd_reg(input logic [1:0] a, input string tag);
    step(1'b0, 8'h00, 1'b1, 1'b0, a, 32'h0, tag);
  endtask

  task automatic wr_ctrl(input logic [31:0] wd, input string tag);
    step(1'b0, 8'h00, 1'b0, 1'b1, 2'd2, wd, tag);
  endtask

  initial begin
    model_reset();
    #12;
    chk("reset_readdata", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic push and ordered pops, then a read of the empty FIFO.
    rd_reg(2'd0, "t1_empty");
    push(8'h41); push(8'h42); push(8'h43);
    rd_reg(2'd0, "t1_pop0"); chk("t1_0x141", readdata, 32'h141);
    rd_reg(2'd0, "t1_pop1"); chk("t1_0x142", readdata, 32'h142);
    rd_reg(2'd0, "t1_pop2"); chk("t1_0x143", readdata, 32'h143);
    rd_reg(2'd0, "t1_pop3"); chk("t1_0x000", readdata, 32'h000);
    rd_reg(2'd1, "t1_status"); chk("t1_status_const", readdata, 32'h0001_0000);

    // Overfill by one byte.
    for (int i = 0; i < DEPTH + 1; i++) push(byte'(8'h10 + i));
    rd_reg(2'd1, "t2_status"); chk("t2_status_const", readdata, 32'h0006_0010);
    for (int i = 0; i < DEPTH; i++) rd_reg(2'd0, "t2_drain");
    wr_ctrl(32'h2, "t2_clr_ovf");
    rd_reg(2'd1, "t2_status_clr");

    // Full FIFO with a coincident push and pop.
    for (int i = 0; i < DEPTH; i++) push(byte'(8'h60 + i));
    step(1'b1, 8'hAA, 1'b1, 1'b0, 2'd0, 32'h0, "t3_pushpop");
    rd_reg(2'd1, "t3_status"); chk("t3_status_const", readdata, 32'h0002_0010);
    for (int i = 0; i < DEPTH; i++) rd_reg(2'd0, "t3_drain");
    chk("t3_last_out", readdata, 32'h1AA);

    // Empty FIFO with push and pop together: pop is a no-op, byte lands.
    step(1'b1, 8'h5C, 1'b1, 1'b0, 2'd0, 32'h0, "t3b_empty_pushpop");
    rd_reg(2'd0, "t3b_pop");

    // Flush with a coincident push, and overflow clear.
    for (int i = 0; i < 5; i++) push(byte'(8'h80 + i));
    step(1'b1, 8'h99, 1'b0, 1'b1, 2'd2, 32'h1, "t4_flush_push");
    rd_reg(2'd1, "t4_status"); chk("t4_status_const", readdata, 32'h0001_0000);
    for (int i = 0; i < DEPTH + 2; i++) push(byte'(8'hC0 + i));
    rd_reg(2'd1, "t4_status_ovf");
    step(1'b1, 8'h77, 1'b0, 1'b1, 2'd2, 32'h3, "t4_flush_clr_full_push");
    rd_reg(2'd1, "t4_status_after"); chk("t4_status_after_const", readdata, 32'h0001_0000);
    for (int i = 0; i < DEPTH; i++) push(byte'(i));
    step(1'b1, 8'h01, 1'b0, 1'b1, 2'd2, 32'h2, "t4_set_clr_same");
    rd_reg(2'd1, "t4_set_wins"); chk("t4_set_wins_const", readdata, 32'h0006_0010);
    wr_ctrl(32'h3, "t4_cleanup");

    // Interrupt enable / CONTROL readback.
    wr_ctrl(32'h4, "t5_wr_ctrl");
    rd_reg(2'd2, "t5_rd_ctrl");
`ifdef UART_RX_PIO_IRQ_EN
    chk("t5_ctrl_const", readdata, 32'h4);
    push(8'h21);
    step(1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 32'h0, "t5_irq_rise");
    chk("t5_irq_high", {31'b0, irq}, 32'h1);
    rd_reg(2'd0, "t5_pop");
    step(1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 32'h0, "t5_irq_fall");
    chk("t5_irq_low", {31'b0, irq}, 32'h0);
`else
    chk("t5_ctrl_const", readdata, 32'h0);
`endif

    // Random traffic, alternating push-heavy and pop-heavy phases.
    for (int i = 0; i < 600; i++) begin
      bit rv, rd, wr;
      logic [1:0] a;
      int pop_pct;
      pop_pct = ((i / 100) % 2 == 1) ? 75 : 20;
      rv = ($urandom_range(0, 99) < 60);
      rd = ($urandom_range(0, 99) < pop_pct);
      a  = rd ? (($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd0)
              : 2'($urandom_range(0, 3));
      wr = ($urandom_range(0, 39) == 0);
      step(rv, byte'($urandom_range(0, 255)), rd, wr, a, $urandom, "rand");
    end
    wr_ctrl(32'h3, "pre_reset_flush");

    // Asynchronous reset with bytes buffered.
    for (int i = 0; i < 8; i++) push(byte'(8'hE0 + i));
    address = 2'd1;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_async_readdata", readdata, 32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    rd_reg(2'd1, "t6_status"); chk("t6_status_const", readdata, 32'h0001_0000);
    rd_reg(2'd0, "t6_data");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
